noc_output_port: RTL and testbench
==================================

Name: noc_output_port

Overview:
- Output side of a router port: takes flits from the crossbar and drives the inter-router link towards the downstream router's input port.
- Holds one credit counter per virtual channel (VC), mirroring free slots in the downstream per-VC FIFOs, so a flit is sent only when the downstream FIFO has space.
- Tracks wormhole packet state per VC. Exports per-VC credit availability to the switch allocator.

Parameters:
- DATA_WIDTH, 64, flit width including the 2-bit type field in the MSBs.
- NUM_VC, 4, number of virtual channels; must be a power of 2 and ≥ 2.
- CREDIT_DEPTH, 4, downstream per-VC FIFO depth; also the reset credit value.
- VCW, $clog2(NUM_VC), VC index width (derived parameter).
- CW, $clog2(CREDIT_DEPTH+1), credit counter width (derived parameter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- xbar_valid  in  1  crossbar presents a flit
- xbar_vc  in  VCW  target VC of the presented flit
- xbar_flit  in  DATA_WIDTH  flit from the crossbar
- xbar_ready  out  1  combinational; flit accepted this cycle when xbar_valid && xbar_ready
- link_valid  out  1  registered; flit valid on the link
- link_vc  out  VCW  registered; VC of the link flit
- link_flit  out  DATA_WIDTH  registered; link flit
- credit_valid  in  1  downstream freed one slot
- credit_vc  in  VCW  VC of the returned credit
- vc_credit_avail  out  NUM_VC  bit i = (credit[i] != 0)
- vc_busy  out  NUM_VC  bit i = VC i is in the ACTIVE state
- err  out  1  sticky protocol error

Behaviour:
- Reset state, applied synchronously:
  - link_valid = 0; link_vc = 0; link_flit = 0.
  - every credit[i] = CREDIT_DEPTH.
  - every VC state = IDLE.
  - err = 0.
  - Consequences: vc_credit_avail = all ones; vc_busy = 0.
  - A reset mid-packet discards all state; no flit is emitted in the cycle after reset.
- Flit type field, flit[DATA_WIDTH-1:DATA_WIDTH-2]:
  - 00 = single (head+tail)
  - 01 = head
  - 10 = body
  - 11 = tail
- xbar_ready is combinational: xbar_ready = !rst && (credit[xbar_vc] != 0). It never depends on xbar_valid.
- Accept: xbar_valid && xbar_ready.
- Forward vs. drop:
  - An accepted legal flit is forwarded.
  - An accepted illegal flit is dropped and sets err. It consumes no credit and is not forwarded.
- Forwarding timing: a flit accepted in cycle N gives link_valid = 1 in cycle N+1, with link_vc/link_flit = the values captured in cycle N. link_valid is 0 in any cycle following a non-accept cycle.
- No backpressure from the link: credits guarantee downstream space. One flit per cycle is sustained while credits last.
- Per-VC state machine (IDLE / ACTIVE); changes happen only on accepted flits of that VC:
  - IDLE: single → legal, stay IDLE. head → legal, go ACTIVE. body or tail → illegal.
  - ACTIVE: body → legal, stay ACTIVE. tail → legal, go IDLE. head or single → illegal, stay ACTIVE.
- Credit counters, evaluated for each VC i in the same cycle:
  - dec = accept of a legal flit on VC i.
  - inc = credit_valid && credit_vc == i.
  - dec && inc: credit unchanged.
  - dec only: credit − 1. It cannot underflow, because xbar_ready gates it.
  - inc only with credit < CREDIT_DEPTH: credit + 1.
  - inc only with credit == CREDIT_DEPTH: overflow; counter holds and err is set.
- Credits returned in cycle N are visible on xbar_ready / vc_credit_avail in cycle N+1.
- err stays 1 until rst. The block keeps operating normally after err is set.
- Different VCs are independent. A credit return on one VC and an accept on another in the same cycle both take effect.

Test Plan:
- Reset check: hold rst for 2 cycles → link_valid = 0, vc_credit_avail = 4'b1111, vc_busy = 0, err = 0, xbar_ready = 1 for every xbar_vc.
- Credit exhaustion: with CREDIT_DEPTH = 4, no credit returns, xbar_valid held on VC0 for 6 cycles with head, body, body, body, tail, … → exactly 4 flits on the link, one per cycle, each 1 cycle after accept. Then xbar_ready = 0, vc_credit_avail[0] = 0, vc_busy[0] = 1. Return one credit on VC0 → next cycle xbar_ready = 1, tail accepted, vc_busy[0] = 0 one cycle after accept.
- Simultaneous event: credit[1] = 2; accept on VC1 and credit_valid with credit_vc = 1 in the same cycle → credit[1] stays 2. Then a credit return on VC2 while accepting on VC3 → credit[2] unchanged at 4 (overflow, err = 1), credit[3] = 3.
- Wormhole violation: body flit to IDLE VC2 → accepted (xbar_ready = 1), no link_valid next cycle, credit[2] = 4, err = 1. Head to ACTIVE VC0 → dropped, VC0 stays ACTIVE.
- Interleave: single on VC0, head on VC1, single on VC3, tail on VC1 in consecutive cycles → link_vc sequence 0, 1, 3, 1 on cycles N+1..N+4, vc_busy = 0 at the end, err = 0.
- Reset mid-packet: head on VC1, then 2 body flits, then rst for 1 cycle → credits all back to 4, vc_busy = 0, link_valid = 0 in the cycle after reset. A head flit on VC1 then forwards without err.

Source files
------------

// File: rtl/noc_output_port.sv
// noc_output_port: output side of a router port.
// Keeps one credit counter and one wormhole state (IDLE/ACTIVE) per VC.
// A flit reaches the link only when the downstream FIFO has space and the
// flit type is legal for the current packet state of its VC.
//
// Handshake: a crossbar flit is accepted in any cycle where xbar_valid and
// xbar_ready are both high. xbar_ready never looks at xbar_valid. The link
// has no ready; credits guarantee space downstream.
module noc_output_port #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_VC       = 4,
    parameter int CREDIT_DEPTH = 4,
    parameter int VCW          = $clog2(NUM_VC),
    parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  xbar_valid,
    input  logic [VCW-1:0]        xbar_vc,
    input  logic [DATA_WIDTH-1:0] xbar_flit,
    output logic                  xbar_ready,
    output logic                  link_valid,
    output logic [VCW-1:0]        link_vc,
    output logic [DATA_WIDTH-1:0] link_flit,
    input  logic                  credit_valid,
    input  logic [VCW-1:0]        credit_vc,
    output logic [NUM_VC-1:0]     vc_credit_avail,
    output logic [NUM_VC-1:0]     vc_busy,
    output logic                  err
);

    localparam logic [1:0] FT_SINGLE = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b10;
    localparam logic [1:0] FT_TAIL   = 2'b11;
    localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);

    typedef enum logic {VC_IDLE = 1'b0, VC_ACTIVE = 1'b1} vc_state_t;

    vc_state_t     vc_state [NUM_VC];
    logic [CW-1:0] credit   [NUM_VC];

    logic [1:0]        flit_type;
    logic              cur_active;
    logic              legal;
    logic              accept;
    logic              fwd;
    logic              overflow;
    logic [NUM_VC-1:0] dec;
    logic [NUM_VC-1:0] inc;
    logic [NUM_VC-1:0] full;

    assign flit_type  = xbar_flit[DATA_WIDTH-1 -: 2];
    assign cur_active = (vc_state[xbar_vc] == VC_ACTIVE);
    assign xbar_ready = !rst && (credit[xbar_vc] != '0);
    assign accept     = xbar_valid && xbar_ready;
    assign fwd        = accept && legal;

    // Legality of the presented flit against the packet state of its VC.
    always_comb begin
        legal = 1'b0;
        case (flit_type)
            FT_SINGLE: legal = !cur_active;
            FT_HEAD:   legal = !cur_active;
            FT_BODY:   legal = cur_active;
            FT_TAIL:   legal = cur_active;
            default:   legal = 1'b0;
        endcase
    end

    // Per-VC credit consume/return strobes, overflow detect and status vectors.
    always_comb begin
        dec             = '0;
        inc             = '0;
        full            = '0;
        vc_credit_avail = '0;
        vc_busy         = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            dec[i]             = fwd && (xbar_vc == VCW'(i));
            inc[i]             = credit_valid && (credit_vc == VCW'(i));
            full[i]            = (credit[i] == CREDIT_FULL);
            vc_credit_avail[i] = (credit[i] != '0);
            vc_busy[i]         = (vc_state[i] == VC_ACTIVE);
        end
        overflow = |(inc & ~dec & full);
    end

    // Credit counters: consume on forward, restore on return, hold when both.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VC; i++) begin
            if (rst) begin
                credit[i] <= CREDIT_FULL;
            end else if (dec[i] && !inc[i]) begin
                credit[i] <= credit[i] - 1'b1;
            end else if (inc[i] && !dec[i] && !full[i]) begin
                credit[i] <= credit[i] + 1'b1;
            end
        end
    end

    // Wormhole state per VC; only forwarded flits move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state[i] <= VC_IDLE;
            end
        end else if (fwd) begin
            if (flit_type == FT_HEAD) begin
                vc_state[xbar_vc] <= VC_ACTIVE;
            end else if (flit_type == FT_TAIL) begin
                vc_state[xbar_vc] <= VC_IDLE;
            end
        end
    end

    // Link register: one cycle after accept, payload held while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_vc    <= '0;
            link_flit  <= '0;
        end else begin
            link_valid <= fwd;
            if (fwd) begin
                link_vc   <= xbar_vc;
                link_flit <= xbar_flit;
            end
        end
    end

    // Sticky error: illegal flit accepted or credit returned to a full counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((accept && !legal) || overflow) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_output_port.sv
// Bench for noc_output_port: directed scenarios plus random traffic, all
// checked every cycle against a packet-level reference model.
module tb_noc_output_port;

    localparam int DW = 64;
    localparam int NV = 4;
    localparam int CD = 4;
    localparam int VW = 2;

    localparam logic [1:0] SINGLE = 2'b00;
    localparam logic [1:0] HEAD   = 2'b01;
    localparam logic [1:0] BODY   = 2'b10;
    localparam logic [1:0] TAIL   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          xbar_valid;
    logic [VW-1:0] xbar_vc;
    logic [DW-1:0] xbar_flit;
    logic          xbar_ready;
    logic          link_valid;
    logic [VW-1:0] link_vc;
    logic [DW-1:0] link_flit;
    logic          credit_valid;
    logic [VW-1:0] credit_vc;
    logic [NV-1:0] vc_credit_avail;
    logic [NV-1:0] vc_busy;
    logic          err;

    noc_output_port #(.DATA_WIDTH(DW), .NUM_VC(NV), .CREDIT_DEPTH(CD)) dut (
        .clk(clk), .rst(rst),
        .xbar_valid(xbar_valid), .xbar_vc(xbar_vc), .xbar_flit(xbar_flit),
        .xbar_ready(xbar_ready),
        .link_valid(link_valid), .link_vc(link_vc), .link_flit(link_flit),
        .credit_valid(credit_valid), .credit_vc(credit_vc),
        .vc_credit_avail(vc_credit_avail), .vc_busy(vc_busy), .err(err)
    );

    // Clock and reset defaults
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: free slots per VC, open-packet flag per VC, sticky error.
    int credits [NV];
    bit in_pkt  [NV];
    bit m_err;
    bit last_fwd;
    logic [VW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            credits[i] = CD;
            in_pkt[i]  = 1'b0;
        end
        m_err = 1'b0;
        exp_q.delete();
    endfunction

    // Whether a flit type fits the packet state of its VC.
    function automatic bit type_ok(input bit open_pkt, input logic [1:0] ty);
        case (ty)
            SINGLE, HEAD: return !open_pkt;
            default:      return open_pkt;
        endcase
    endfunction

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic step(input bit r, input bit v, input int vc, input logic [1:0] ty,
                        input bit cv, input int cvc);
        logic [DW-1:0]    f;
        logic [VW+DW-1:0] e;
        bit               exp_ready;
        bit               fwd;
        logic [NV-1:0]    exp_avail;
        logic [NV-1:0]    exp_busy;
        f = {ty, $urandom(), 30'($urandom())};
        @(negedge clk);
        rst          = r;
        xbar_valid   = v;
        xbar_vc      = VW'(vc);
        xbar_flit    = f;
        credit_valid = cv;
        credit_vc    = VW'(cvc);
        #1;
        exp_ready = !r && (credits[vc] > 0);
        check("xbar_ready", xbar_ready, exp_ready);
        fwd = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            if (v && exp_ready) begin
                if (type_ok(in_pkt[vc], ty)) begin
                    fwd = 1'b1;
                    credits[vc]--;
                    if (ty == HEAD) in_pkt[vc] = 1'b1;
                    if (ty == TAIL) in_pkt[vc] = 1'b0;
                    exp_q.push_back({VW'(vc), f});
                end else begin
                    m_err = 1'b1;
                end
            end
            if (cv) begin
                if (credits[cvc] == CD) m_err = 1'b1;
                else credits[cvc]++;
            end
        end
        last_fwd = fwd;
        @(posedge clk);
        #1;
        check("link_valid", link_valid, fwd);
        if (link_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("link_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("link_vc", link_vc, e[VW+DW-1:DW]);
                check("link_flit", link_flit, e[DW-1:0]);
            end
        end
        for (int i = 0; i < NV; i++) begin
            exp_avail[i] = (credits[i] > 0);
            exp_busy[i]  = in_pkt[i];
        end
        check("vc_credit_avail", vc_credit_avail, exp_avail);
        check("vc_busy", vc_busy, exp_busy);
        check("err", err, m_err);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, SINGLE, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, SINGLE, 0, 0);
    endtask

    initial begin
        rst = 1'b1; xbar_valid = 1'b0; xbar_vc = '0; xbar_flit = '0;
        credit_valid = 1'b0; credit_vc = '0;
        model_reset();

        // Reset state, and ready on every VC
        do_reset(2);
        check("rst_link_valid", link_valid, 0);
        check("rst_avail", vc_credit_avail, 4'b1111);
        check("rst_busy", vc_busy, 0);
        check("rst_err", err, 0);
        for (int i = 0; i < NV; i++) step(0, 0, i, SINGLE, 0, 0);

        // Credit exhaustion on VC0
        step(0, 1, 0, HEAD, 0, 0);
        step(0, 1, 0, BODY, 0, 0);
        step(0, 1, 0, BODY, 0, 0);
        step(0, 1, 0, BODY, 0, 0);
        step(0, 1, 0, TAIL, 0, 0);
        step(0, 1, 0, TAIL, 0, 0);
        check("exh_ready", xbar_ready, 0);
        check("exh_avail0", vc_credit_avail[0], 0);
        check("exh_busy0", vc_busy[0], 1);
        step(0, 0, 0, TAIL, 1, 0);
        step(0, 1, 0, TAIL, 0, 0);
        check("exh_done_busy0", vc_busy[0], 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, SINGLE, 1, 0);

        // Simultaneous accept and return on VC1, then return on full VC2
        step(0, 1, 1, HEAD, 0, 0);
        step(0, 1, 1, BODY, 0, 0);
        step(0, 1, 1, BODY, 1, 1);
        step(0, 1, 3, SINGLE, 1, 2);
        check("sim_err", err, 1);
        step(0, 1, 1, TAIL, 0, 0);
        step(0, 1, 1, SINGLE, 0, 0);
        step(0, 1, 1, SINGLE, 0, 0);
        check("sim_vc1_drained", vc_credit_avail[1], 0);

        // Wormhole violations
        do_reset(1);
        step(0, 1, 2, BODY, 0, 0);
        check("wh_body_drop", link_valid, 0);
        check("wh_err", err, 1);
        step(0, 1, 0, HEAD, 0, 0);
        step(0, 1, 0, HEAD, 0, 0);
        check("wh_head_drop", link_valid, 0);
        check("wh_vc0_busy", vc_busy[0], 1);
        step(0, 1, 0, TAIL, 0, 0);

        // Interleaved VCs
        do_reset(1);
        step(0, 1, 0, SINGLE, 0, 0);
        step(0, 1, 1, HEAD, 0, 0);
        step(0, 1, 3, SINGLE, 0, 0);
        step(0, 1, 1, TAIL, 0, 0);
        check("il_last_vc", link_vc, 1);
        check("il_busy", vc_busy, 0);
        check("il_err", err, 0);

        // Reset in the middle of a packet, with a flit still offered
        step(0, 1, 1, HEAD, 0, 0);
        step(0, 1, 1, BODY, 0, 0);
        step(0, 1, 1, BODY, 0, 0);
        step(1, 1, 1, BODY, 0, 0);
        check("mid_avail", vc_credit_avail, 4'b1111);
        check("mid_link", link_valid, 0);
        step(0, 1, 1, HEAD, 0, 0);
        check("mid_head_fwd", link_valid, 1);
        check("mid_err", err, 0);
        step(0, 1, 1, TAIL, 0, 0);

        // Random traffic, mostly legal, returns mostly to VCs owing credit
        for (int k = 0; k < 600; k++) begin
            int vc;
            int cvc;
            logic [1:0] ty;
            bit r;
            bit cv;
            vc = $urandom_range(NV - 1);
            if ($urandom_range(9) < 8) begin
                ty = in_pkt[vc] ? ($urandom_range(2) == 0 ? TAIL : BODY)
                                : ($urandom_range(1) == 0 ? HEAD : SINGLE);
            end else begin
                ty = 2'($urandom_range(3));
            end
            cvc = $urandom_range(NV - 1);
            for (int j = 0; j < NV; j++) begin
                if (credits[cvc] == CD && $urandom_range(7) != 0) cvc = (cvc + 1) % NV;
            end
            cv = ($urandom_range(9) < 5) && !last_fwd ? 1'b1 : ($urandom_range(1) == 1);
            r  = ($urandom_range(199) == 0);
            step(r, $urandom_range(3) != 0, vc, ty, cv, cvc);
        end

        idle(2);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
